// File: rtl/mux4_rr_sel_pkg.sv
// Shared definitions for the round-robin select generator and the 4:1 mux it drives.
package mux4_rr_sel_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic logic [NUM_CH-1:0] one_hot(input logic [SEL_W-1:0] idx);
    one_hot      = '0;
    one_hot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/mux4_rr_sel_rr_pick4.sv
// Combinational round-robin pick: first set request strictly after the pointer, wrapping.
module rr_pick4
  import mux4_rr_sel_pkg::*;
(
  input  logic [NUM_CH-1:0] req_in,
  input  logic [SEL_W-1:0]  ptr_in,
  output logic [SEL_W-1:0]  winner_out,
  output logic              any_req_out
);

  logic             found;
  logic [SEL_W-1:0] idx;

  always_comb begin
    winner_out = '0;
    found      = 1'b0;
    idx        = '0;
    // Offsets 1..NUM_CH: the pointer's own channel is searched last.
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = ptr_in + SEL_W'(k);
      if (!found && req_in[idx]) begin
        winner_out = idx;
        found      = 1'b1;
      end
    end
    any_req_out = |req_in;
  end

endmodule

// File: rtl/mux4_rr_sel.sv
// Round-robin arbiter producing a registered, glitch-free select and one-hot grant
// for a 4:1 mux; grants are held until release or MAX_HOLD cycles elapse.
module mux4_rr_sel
  import mux4_rr_sel_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req_in,
  input  logic              done_in,
  output logic [SEL_W-1:0]  sel_out,
  output logic [NUM_CH-1:0] grant_out,
  output logic              valid_out,
  output logic              timeout_out
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [NUM_CH-1:0]  grant_q, grant_d;
  logic               valid_q, valid_d;
  logic               timeout_q, timeout_d;

  logic               owner_req;
  logic               at_max;
  logic               rel_now;
  logic [SEL_W-1:0]   pick_ptr;
  logic [NUM_CH-1:0]  pick_req;
  logic [SEL_W-1:0]   pick_win;
  logic               pick_any;

  // While granted the search starts after the owner and masks it out,
  // so a release always hands over to someone else if anyone is waiting.
  always_comb begin
    owner_req = req_in[sel_q];
    at_max    = (cnt_q == CNT_W'(MAX_HOLD));
    rel_now   = (state_q == GRANT) && (done_in || !owner_req || at_max);
    if (state_q == GRANT) begin
      pick_ptr = sel_q;
      pick_req = req_in & ~one_hot(sel_q);
    end else begin
      pick_ptr = ptr_q;
      pick_req = req_in;
    end
  end

  rr_pick4 u_pick (
    .req_in      (pick_req),
    .ptr_in      (pick_ptr),
    .winner_out  (pick_win),
    .any_req_out (pick_any)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ptr_q     <= SEL_W'(NUM_CH - 1);
      sel_q     <= '0;
      grant_q   <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      grant_q   <= grant_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_any) state_d = GRANT;
      GRANT:   if (rel_now && !pick_any) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    grant_d   = grant_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          sel_d   = pick_win;
          grant_d = one_hot(pick_win);
          valid_d = 1'b1;
          cnt_d   = CNT_W'(1);
        end
      end
      GRANT: begin
        if (rel_now) begin
          ptr_d     = sel_q;
          // A voluntary release in the same cycle wins over the timeout.
          timeout_d = at_max && !done_in && owner_req;
          if (pick_any) begin
            sel_d   = pick_win;
            grant_d = one_hot(pick_win);
            valid_d = 1'b1;
            cnt_d   = CNT_W'(1);
          end else begin
            grant_d = '0;
            valid_d = 1'b0;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign sel_out     = sel_q;
  assign grant_out   = grant_q;
  assign valid_out   = valid_q;
  assign timeout_out = timeout_q;

endmodule

// File: tb/tb_mux4_rr_sel.sv
// Bench for mux4_rr_sel: directed vector table, reset-mid-grant sequence, then random
// traffic against a behavioural model with one-hot, select and wait-bound checks.
module tb_mux4_rr_sel;

  localparam int MAX_HOLD   = 8;
  localparam int WAIT_LIMIT = 3 * MAX_HOLD + 3;
  localparam int RAND_CYC   = 10000;

  logic       clock;
  logic       reset;
  logic [3:0] req_in;
  logic       done_in;
  logic [1:0] sel_out;
  logic [3:0] grant_out;
  logic       valid_out;
  logic       timeout_out;

  int n_vec;
  int n_miss;

  mux4_rr_sel #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_in      (req_in),
    .done_in     (done_in),
    .sel_out     (sel_out),
    .grant_out   (grant_out),
    .valid_out   (valid_out),
    .timeout_out (timeout_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       valid;
    logic       tmo;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [3:0] r, input logic d, input logic [1:0] s,
                              input logic [3:0] g, input logic v, input logic t, input int n);
    vec_t e;
    e.req = r; e.done = d; e.sel = s; e.grant = g; e.valid = v; e.tmo = t;
    for (int i = 0; i < n; i++) vecs.push_back(e);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: owner index (-1 when idle), cycles held, last owner.
  int m_owner, m_sel, m_cnt, m_ptr;
  bit m_to;

  function automatic void model_reset();
    m_owner = -1; m_sel = 0; m_cnt = 0; m_ptr = 3; m_to = 0;
  endfunction

  function automatic int pick(input logic [3:0] r, input int ptr, input int excl);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (ptr + k) % 4;
      if (r[c] && c != excl) return c;
    end
    return -1;
  endfunction

  function automatic void model_step(input logic [3:0] r, input logic d);
    int w;
    m_to = 0;
    if (m_owner < 0) begin
      w = pick(r, m_ptr, -1);
      if (w >= 0) begin m_owner = w; m_sel = w; m_cnt = 1; end
    end else if (d || !r[m_owner] || m_cnt == MAX_HOLD) begin
      m_to  = !d && r[m_owner] && (m_cnt == MAX_HOLD);
      m_ptr = m_owner;
      w = pick(r, m_owner, m_owner);
      if (w >= 0) begin m_owner = w; m_sel = w; m_cnt = 1; end
      else m_owner = -1;
    end else begin
      m_cnt++;
    end
  endfunction

  function automatic logic [7:0] model_outs();
    logic [3:0] g;
    g = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    return {2'(m_sel), g, (m_owner >= 0), m_to};
  endfunction

  int         waits[4];
  logic [3:0] cur_req;

  initial begin
    n_vec = 0; n_miss = 0;
    reset = 1'b1; req_in = 4'b0000; done_in = 1'b0;

    add(4'b0000, 0, 2'd0, 4'b0000, 0, 0, 2);
    add(4'b1111, 0, 2'd0, 4'b0001, 1, 0, 3);
    add(4'b1111, 1, 2'd1, 4'b0010, 1, 0, 1);
    add(4'b1111, 0, 2'd1, 4'b0010, 1, 0, 2);
    add(4'b1111, 1, 2'd2, 4'b0100, 1, 0, 1);
    add(4'b1111, 0, 2'd2, 4'b0100, 1, 0, 2);
    add(4'b1111, 1, 2'd3, 4'b1000, 1, 0, 1);
    add(4'b1111, 0, 2'd3, 4'b1000, 1, 0, 2);
    add(4'b1111, 1, 2'd0, 4'b0001, 1, 0, 1);
    add(4'b0010, 1, 2'd1, 4'b0010, 1, 0, 1);
    add(4'b1001, 0, 2'd3, 4'b1000, 1, 0, 1);
    add(4'b1001, 1, 2'd0, 4'b0001, 1, 0, 1);
    add(4'b0000, 0, 2'd0, 4'b0000, 0, 0, 1);
    add(4'b0100, 0, 2'd2, 4'b0100, 1, 0, MAX_HOLD);
    add(4'b0100, 0, 2'd2, 4'b0000, 0, 1, 1);
    add(4'b0100, 0, 2'd2, 4'b0100, 1, 0, MAX_HOLD);
    add(4'b0100, 1, 2'd2, 4'b0000, 0, 0, 1);
    add(4'b0000, 0, 2'd2, 4'b0000, 0, 0, 1);

    #1;
    check("reset_outputs", {sel_out, grant_out, valid_out, timeout_out}, 8'h00);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    foreach (vecs[i]) begin
      req_in  = vecs[i].req;
      done_in = vecs[i].done;
      @(posedge clock);
      #1;
      check($sformatf("vec%0d", i), {sel_out, grant_out, valid_out, timeout_out},
            {vecs[i].sel, vecs[i].grant, vecs[i].valid, vecs[i].tmo});
    end

    // Reset mid-grant: outputs must clear before any clock edge, pointer back to 3.
    req_in = 4'b0010; done_in = 1'b0;
    @(posedge clock);
    #1;
    check("pre_reset_grant", {sel_out, grant_out, valid_out}, {2'd1, 4'b0010, 1'b1});
    #3;
    reset = 1'b1;
    #1;
    check("async_reset_clear", {sel_out, grant_out, valid_out, timeout_out}, 8'h00);
    @(negedge clock);
    reset = 1'b0;
    req_in = 4'b1010;
    @(posedge clock);
    #1;
    check("post_reset_priority", {sel_out, grant_out, valid_out}, {2'd1, 4'b0010, 1'b1});

    // Random traffic against the model.
    reset = 1'b1;
    req_in = 4'b0000; done_in = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) waits[i] = 0;
    @(negedge clock);
    reset = 1'b0;
    cur_req = 4'b0000;
    for (int cyc = 0; cyc < RAND_CYC; cyc++) begin
      logic [7:0] exp_o;
      int         worst;
      for (int b = 0; b < 4; b++)
        if ($urandom_range(3) == 0) cur_req[b] = ~cur_req[b];
      req_in  = cur_req;
      done_in = ($urandom_range(7) == 0);
      @(posedge clock);
      model_step(req_in, done_in);
      #1;
      exp_o = model_outs();
      check("rand_outputs", {sel_out, grant_out, valid_out, timeout_out}, {24'd0, exp_o});
      check("rand_onehot", $onehot0(grant_out), 1);
      check("rand_sel_valid", grant_out[sel_out], valid_out);
      worst = 0;
      for (int c = 0; c < 4; c++) begin
        if (req_in[c] && !grant_out[c]) waits[c]++;
        else waits[c] = 0;
        if (waits[c] > worst) worst = waits[c];
      end
      check("rand_wait_bound", (worst > WAIT_LIMIT), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mux4_rr_sel.md
Name: mux4_rr_sel

Overview:
- Round-robin arbiter and select generator that sits directly upstream of the 4:1 data multiplexer.
- Takes four per-channel requests and picks one owner. Drives the 2-bit select that steers that channel's bit onto the mux output.
- Holds each grant until the owner releases or a hold-timeout expires, then rotates fairly to the next requester.

Parameters:
- MAX_HOLD, 8, maximum consecutive GRANT cycles per ownership; legal range 1..255.
- CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clock  input  1  single system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- req_in  input  4  per-channel request; bit i = channel i wants the mux
- done_in  input  1  owner releases the grant this cycle; ignored when not in GRANT
- sel_out  output  2  registered select to the mux sel_in; index of current owner
- grant_out  output  4  registered one-hot grant; all zero when idle
- valid_out  output  1  high when sel_out names a live owner (mux output meaningful)
- timeout_out  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD

Behaviour:
- Reset, asynchronous, immediate on assertion:
  - sel_out=0, grant_out=0, valid_out=0, timeout_out=0
  - state=IDLE, hold counter=0, last-owner pointer=3, so channel 0 has first priority.
- States: IDLE, GRANT.
- Arbitration function:
  - Search order starts at pointer+1 and wraps modulo 4: pointer 3 gives order 0,1,2,3; pointer 1 gives order 2,3,0,1.
  - The first set req_in bit in that order wins.
- IDLE:
  - No req_in bit set: stay in IDLE, outputs unchanged (idle values).
  - Any req_in bit set: next edge loads sel_out=winner, grant_out=one-hot(winner), valid_out=1, counter=1, and moves to GRANT.
  - Latency from req_in rising to valid_out is 1 clock.
- GRANT, release conditions (any one):
  - done_in=1
  - req_in[sel_out]=0
  - counter==MAX_HOLD, which is the timeout.
- GRANT, on release:
  - pointer <= sel_out.
  - Arbitration runs in the same cycle with the updated pointer. The current owner is excluded from the search in that cycle, even if it is still requesting.
  - Another channel requesting: next edge grants it directly (back-to-back, no idle bubble); counter=1, stay in GRANT.
  - No other channel requesting: next edge goes to IDLE with grant_out=0, valid_out=0. sel_out holds its last value.
- GRANT, no release: counter increments by 1 and all outputs hold.
- timeout_out:
  - Pulses high on the edge that ends a grant because counter==MAX_HOLD.
  - Does not pulse if done_in or a request drop coincides with the timeout; a voluntary release takes precedence.
- Simultaneous events:
  - done_in together with a new request from another channel: that channel is granted on the next edge.
  - Requests from a channel that arrive while another channel owns the mux are queued implicitly by the request level. Nothing is latched.
- Single requester held continuously:
  - With done_in=0, it gets MAX_HOLD cycles of GRANT, then one IDLE cycle (no one else requesting), then is re-granted.
  - Its grant therefore cannot exceed MAX_HOLD consecutive cycles.
- Reset mid-grant: outputs clear immediately (asynchronously) and the pointer returns to 3.
- Invariants:
  - grant_out is always zero or one-hot.
  - grant_out[sel_out]==valid_out.
  - sel_out changes only on a clock edge, so the downstream mux sees a glitch-free registered select.

Decomposition:
- Shared package: state encoding (IDLE=1'b0, GRANT=1'b1) and the NUM_CH=4 / SEL_W=2 constants used by both this block and the mux.
- One natural sub-module, rr_pick4: purely combinational. It takes the 4-bit request and the 2-bit pointer and returns the 2-bit winner plus an any_req flag.
- The top block holds the FSM, hold counter, pointer and output registers.

Test Plan:
- Reset release with req_in=4'b0000 -> valid_out=0, grant_out=0, sel_out=0 indefinitely; assert reset mid-grant -> all outputs zero in the same cycle.
- req_in=4'b1111 held, done_in pulsed every 3rd cycle of each grant -> sel_out sequence 0,1,2,3,0 with no idle cycles between grants, grant_out one-hot matching.
- req_in=4'b0100 only, done_in=0, MAX_HOLD=8 -> sel_out=2 valid for exactly 8 cycles, timeout_out pulse, 1 idle cycle, re-grant to 2.
- Owner 1 granted; req_in[1] drops while req_in[3] and req_in[0] are set -> next grant is 3, the one after is 0.
- In the same cycle, counter reaches MAX_HOLD and done_in=1 -> grant released, timeout_out stays 0.
- Random req_in/done_in for 10k cycles, with a scoreboard checking one-hot grant, the rotation order, and that no channel waits more than 3×MAX_HOLD+3 cycles while requesting.
